// File: rtl/dsp_result_collector_if.sv
// Handshake bundle between the DSP48A1 issue/result side and the collector.
// slave = collector side, master = upstream/downstream driver side.
interface dsp_result_collector_if #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ISSUE_VALID;
  logic             ISSUE_READY;
  logic [WIDTH-1:0] P_IN;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [CW-1:0]    IN_FLIGHT;
  logic             OVERFLOW;

  modport slave (
    input  ISSUE_VALID, P_IN, OUT_READY,
    output ISSUE_READY, OUT_DATA, OUT_VALID, IN_FLIGHT, OVERFLOW
  );

  modport master (
    output ISSUE_VALID, P_IN, OUT_READY,
    input  ISSUE_READY, OUT_DATA, OUT_VALID, IN_FLIGHT, OVERFLOW
  );
endinterface

// File: rtl/dsp_result_collector.sv
// Tracks operations issued into a fixed-latency DSP slice, captures P LATENCY cycles later
// into a show-ahead FIFO, and gates issue on credits so no result can be dropped.
module dsp_result_collector #(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RSTIN,
  dsp_result_collector_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    in_flight_q, in_flight_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             overflow_q, overflow_d;

  logic [CW:0] credit_used;
  logic        issue_ready, fire, capture, pop, full, push_ok;

  // Credit is derived from registered state only, so a pop frees a slot next cycle.
  assign credit_used = {1'b0, in_flight_q} + {1'b0, count_q};
  assign issue_ready = credit_used < (CW+1)'(DEPTH);
  assign fire        = bus.ISSUE_VALID & issue_ready;

  generate
    if (LATENCY > 0) begin : g_pipe
      logic [LATENCY-1:0] vld_q, vld_d;
      always_comb vld_d = (vld_q << 1) | LATENCY'(fire);
      always_ff @(posedge CLK) begin
        if (RSTIN) vld_q <= '0;
        else       vld_q <= vld_d;
      end
      assign capture = vld_q[LATENCY-1];
    end else begin : g_nopipe
      assign capture = fire;
    end
  endgenerate

  assign full    = count_q == CW'(DEPTH);
  assign pop     = (count_q != '0) & bus.OUT_READY;
  assign push_ok = capture & (~full | pop);

  always_comb begin
    in_flight_d = in_flight_q + CW'(fire) - CW'(capture);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push_ok) - CW'(pop);
    overflow_d  = overflow_q | (capture & full & ~pop);
    if (push_ok) begin
      mem_d[wr_ptr_q] = bus.P_IN;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RSTIN) begin
      in_flight_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      overflow_q  <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.ISSUE_READY = issue_ready;
  assign bus.OUT_DATA    = mem_q[rd_ptr_q];
  assign bus.OUT_VALID   = count_q != '0;
  assign bus.IN_FLIGHT   = in_flight_q;
  assign bus.OVERFLOW    = overflow_q;
endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench: a LATENCY=4 collector driven from a vector table plus corner sequences,
// and a LATENCY=0 collector for the same-edge capture case.
module tb_dsp_result_collector;
  logic CLK = 1'b0;
  logic RSTIN;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  dsp_result_collector_if #(.WIDTH(48), .DEPTH(4)) a_if ();
  dsp_result_collector_if #(.WIDTH(48), .DEPTH(4)) b_if ();

  dsp_result_collector #(.WIDTH(48), .LATENCY(4), .DEPTH(4)) dut_a (
    .CLK(CLK), .RSTIN(RSTIN), .bus(a_if.slave));
  dsp_result_collector #(.WIDTH(48), .LATENCY(0), .DEPTH(4)) dut_b (
    .CLK(CLK), .RSTIN(RSTIN), .bus(b_if.slave));

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [47:0] p;
    logic        e_ov;
    logic [47:0] e_data;
    logic        e_irdy;
    logic [2:0]  e_inf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic        pv [4];
    int          pidx [4];
    logic [47:0] res [$];
    int          fired, got;
    logic        f;

    // latency: single issue, P valid only 4 edges later, popped the cycle after
    tbl.push_back('{1'b1, 1'b1, 48'h0,            1'b0, 48'h0,            1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0,            1'b0, 48'h0,            1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0,            1'b0, 48'h0,            1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0,            1'b0, 48'h0,            1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0000_1234_5678, 1'b1, 48'h0000_1234_5678, 1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 48'h0,            1'b0, 48'h0,            1'b1, 3'd0});
    // backpressure: four fires exhaust credit, results fill the FIFO
    tbl.push_back('{1'b1, 1'b0, 48'h0,  1'b0, 48'h0,  1'b1, 3'd1});
    tbl.push_back('{1'b1, 1'b0, 48'h0,  1'b0, 48'h0,  1'b1, 3'd2});
    tbl.push_back('{1'b1, 1'b0, 48'h0,  1'b0, 48'h0,  1'b1, 3'd3});
    tbl.push_back('{1'b1, 1'b0, 48'h0,  1'b0, 48'h0,  1'b0, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 48'hA0, 1'b1, 48'hA0, 1'b0, 3'd3});
    tbl.push_back('{1'b1, 1'b0, 48'hA1, 1'b1, 48'hA0, 1'b0, 3'd2});
    tbl.push_back('{1'b1, 1'b0, 48'hA2, 1'b1, 48'hA0, 1'b0, 3'd1});
    tbl.push_back('{1'b1, 1'b0, 48'hA3, 1'b1, 48'hA0, 1'b0, 3'd0});
    tbl.push_back('{1'b1, 1'b0, 48'hFF, 1'b1, 48'hA0, 1'b0, 3'd0});
    // drain in order, then issuing resumes
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b1, 48'hA1, 1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b1, 48'hA2, 1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b1, 48'hA3, 1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b0, 48'h0,  1'b1, 3'd0});
    tbl.push_back('{1'b1, 1'b1, 48'h0,  1'b0, 48'h0,  1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b0, 48'h0,  1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b0, 48'h0,  1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b0, 48'h0,  1'b1, 3'd1});
    tbl.push_back('{1'b0, 1'b1, 48'h55, 1'b1, 48'h55, 1'b1, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 48'h0,  1'b0, 48'h0,  1'b1, 3'd0});

    // reset held two edges with issue requested
    RSTIN = 1'b1;
    a_if.ISSUE_VALID = 1'b1; a_if.OUT_READY = 1'b0; a_if.P_IN = 48'h1;
    b_if.ISSUE_VALID = 1'b1; b_if.OUT_READY = 1'b0; b_if.P_IN = 48'h2;
    tick();
    tick();
    chk("rst_a_inflight", 64'(a_if.IN_FLIGHT), 64'd0);
    chk("rst_b_ovalid",   64'(b_if.OUT_VALID), 64'd0);
    RSTIN = 1'b0;
    a_if.ISSUE_VALID = 1'b0; b_if.ISSUE_VALID = 1'b0;
    #1;
    chk("rst_a_ovalid",   64'(a_if.OUT_VALID),   64'd0);
    chk("rst_a_odata",    64'(a_if.OUT_DATA),    64'd0);
    chk("rst_a_irdy",     64'(a_if.ISSUE_READY), 64'd1);
    chk("rst_a_ovf",      64'(a_if.OVERFLOW),    64'd0);
    chk("rst_b_inflight", 64'(b_if.IN_FLIGHT),   64'd0);
    chk("rst_b_irdy",     64'(b_if.ISSUE_READY), 64'd1);

    foreach (tbl[i]) begin
      a_if.ISSUE_VALID = tbl[i].iv;
      a_if.OUT_READY   = tbl[i].ordy;
      a_if.P_IN        = tbl[i].p;
      tick();
      chk($sformatf("vec%0d_ovalid", i),   64'(a_if.OUT_VALID),   64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_irdy", i),     64'(a_if.ISSUE_READY), 64'(tbl[i].e_irdy));
      chk($sformatf("vec%0d_inflight", i), 64'(a_if.IN_FLIGHT),   64'(tbl[i].e_inf));
      chk($sformatf("vec%0d_ovf", i),      64'(a_if.OVERFLOW),    64'd0);
      if (tbl[i].e_ov)
        chk($sformatf("vec%0d_odata", i),  64'(a_if.OUT_DATA),    64'(tbl[i].e_data));
    end

    // streaming: 10 issues, slice model returns the issue index 4 edges later
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pidx[k] = 0; end
    fired = 0; got = 0;
    a_if.OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      a_if.ISSUE_VALID = (fired < 10);
      a_if.P_IN        = pv[3] ? 48'(pidx[3]) : 48'hBAD;
      f = a_if.ISSUE_VALID & a_if.ISSUE_READY;
      tick();
      for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pidx[k] = pidx[k-1]; end
      pv[0] = f; pidx[0] = fired;
      if (f) fired++;
      if (a_if.OUT_VALID) begin res.push_back(a_if.OUT_DATA); got++; end
    end
    chk("stream_count", 64'(got), 64'd10);
    foreach (res[i]) chk($sformatf("stream_res%0d", i), 64'(res[i]), 64'(i));
    a_if.ISSUE_VALID = 1'b0;
    tick();
    chk("stream_empty", 64'(a_if.OUT_VALID), 64'd0);
    chk("stream_ovf",   64'(a_if.OVERFLOW),  64'd0);

    // LATENCY=0: captured on the issue edge itself
    b_if.ISSUE_VALID = 1'b1; b_if.P_IN = 48'hABC; b_if.OUT_READY = 1'b0;
    tick();
    chk("lat0_ovalid",   64'(b_if.OUT_VALID), 64'd1);
    chk("lat0_odata",    64'(b_if.OUT_DATA),  64'hABC);
    chk("lat0_inflight", 64'(b_if.IN_FLIGHT), 64'd0);
    b_if.ISSUE_VALID = 1'b0; b_if.OUT_READY = 1'b1; b_if.P_IN = 48'h0;
    tick();
    chk("lat0_popped",   64'(b_if.OUT_VALID), 64'd0);
    chk("lat0_ovf",      64'(b_if.OVERFLOW),  64'd0);

    // reset mid-flight: 3 in flight plus 1 buffered
    a_if.OUT_READY = 1'b0; a_if.P_IN = 48'h0; a_if.ISSUE_VALID = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    a_if.ISSUE_VALID = 1'b0; a_if.P_IN = 48'h777;
    tick();
    chk("mid_pre_inflight", 64'(a_if.IN_FLIGHT), 64'd3);
    chk("mid_pre_ovalid",   64'(a_if.OUT_VALID), 64'd1);
    RSTIN = 1'b1; a_if.P_IN = 48'h888;
    tick();
    RSTIN = 1'b0;
    chk("mid_rst_ovalid",   64'(a_if.OUT_VALID),   64'd0);
    chk("mid_rst_inflight", 64'(a_if.IN_FLIGHT),   64'd0);
    chk("mid_rst_irdy",     64'(a_if.ISSUE_READY), 64'd1);
    a_if.OUT_READY = 1'b1; a_if.P_IN = 48'h999;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("mid_quiet%0d_ovalid", k),   64'(a_if.OUT_VALID), 64'd0);
      chk($sformatf("mid_quiet%0d_inflight", k), 64'(a_if.IN_FLIGHT), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
